// File: rtl/pe_array_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_seq_ctrl
// Purpose  : Per-tile sequencer for the 16-core 3x3 convolution PE array.
//            Loads the kernel taps into all cores through weight_valid. Issues
//            one bias or residual-add load to core 0 through bias_valid. Streams
//            cfg_len feature beats qualified by pulse. It then waits for the MAC
//            pipeline to drain and pulses done.
// Ports    : DSP_clk / rst_n (async, active-low)
//            start, cfg_len, cfg_adder           - tile command, sampled in IDLE
//            busy, done                          - tile status
//            w_src_*, b_src_*, f_src_*           - valid/ready from the buffers
//            weight_valid, bias_valid, pulse,
//            bias_or_adder_feature               - PE array control pins
//            stall_cnt (PE_SEQ_STALL_CNT_EN)     - RUN cycles starved of features
// Options  : define PE_SEQ_STALL_CNT_EN to add the saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pe_array_seq_ctrl #(
  parameter int KERNEL_TAPS  = 9,
  parameter int LEN_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 DSP_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_adder,
  output logic                 busy,
  output logic                 done,
  input  logic                 w_src_valid,
  output logic                 w_src_ready,
  input  logic                 b_src_valid,
  output logic                 b_src_ready,
  input  logic                 f_src_valid,
  output logic                 f_src_ready,
  output logic                 weight_valid,
  output logic                 bias_valid,
  output logic                 bias_or_adder_feature,
`ifdef PE_SEQ_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  output logic                 pulse
);

  localparam int TAP_W = (KERNEL_TAPS > 1)  ? $clog2(KERNEL_TAPS)  : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [TAP_W-1:0] c_tap_last = TAP_W'(KERNEL_TAPS - 1);
  localparam logic [DRN_W-1:0] c_drn_last = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_adder;
  logic [TAP_W-1:0]     r_tap_cnt;
  logic [LEN_WIDTH-1:0] r_beat_cnt;
  logic [DRN_W-1:0]     r_drn_cnt;

  logic w_start_acc;
  logic w_tap_last;
  logic w_beat_last;
  logic w_drn_last;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_tap_last  = (r_tap_cnt == c_tap_last);
  // RUN is only entered with r_len >= 1, so r_len - 1 never underflows there.
  assign w_beat_last = (r_beat_cnt == (r_len - 1'b1));
  assign w_drn_last  = (r_drn_cnt == c_drn_last);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and ready decode. Readies depend on the state only, so a
  // source can never create a combinational loop through its own valid.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_src_ready = 1'b0;
    b_src_ready = 1'b0;
    f_src_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_src_ready = 1'b1;
        if (w_src_valid && w_tap_last) w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_src_ready = 1'b1;
        if (b_src_valid) w_state_nxt = (r_len == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        f_src_ready = 1'b1;
        if (f_src_valid && w_beat_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drn_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Tile configuration and phase counters. Each counter wraps back to zero on
  // its final step, so it is already clear the next time its phase starts.
  // --------------------------------------------------------------------------
  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_adder    <= 1'b0;
      r_tap_cnt  <= '0;
      r_beat_cnt <= '0;
      r_drn_cnt  <= '0;
    end else begin
      if (w_start_acc) begin
        r_len   <= cfg_len;
        r_adder <= cfg_adder;
      end
      if ((r_state == S_LOAD_W) && w_src_valid) begin
        r_tap_cnt <= w_tap_last ? '0 : r_tap_cnt + 1'b1;
      end
      if ((r_state == S_RUN) && f_src_valid) begin
        r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + 1'b1;
      end
      if (r_state == S_DRAIN) begin
        r_drn_cnt <= w_drn_last ? '0 : r_drn_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Everything is decoded from r_state, so an async reset drops
  // every output to zero without waiting for a clock.
  // --------------------------------------------------------------------------
  assign busy                  = (r_state != S_IDLE);
  assign done                  = (r_state == S_DONE);
  assign weight_valid          = w_src_valid & w_src_ready;
  assign bias_valid            = b_src_valid & b_src_ready;
  assign pulse                 = f_src_valid & f_src_ready;
  assign bias_or_adder_feature = r_adder & busy;

`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && !f_src_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
